// File: rtl/mcrc_txframer.sv
// mcrc_txframer: MODBUS RTU transmit framer.
// Forwards payload bytes through a single output register, runs a MODBUS
// CRC-16 (init 0xFFFF, reflected poly 0xA001) over them and appends the CRC
// low byte then high byte, flagging the high byte as the end of frame.
// Payload bytes beyond MAXLEN-2 are acknowledged but dropped, and the sticky
// oversize flag records that this happened.

module mcrc_txframer #(
    parameter int MAXLEN = 256,
    parameter int LWIDTH = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        out_last,
    input  logic        out_ready,
    output logic        busy,
    output logic        oversize,
    output logic [15:0] frame_count
);

    typedef enum logic [1:0] {
        ST_DATA,
        ST_CRCLO,
        ST_CRCHI
    } state_t;

    // Largest number of payload bytes that still leaves room for the CRC.
    localparam logic [LWIDTH-1:0] PAYMAX = LWIDTH'(MAXLEN - 2);

    state_t            state;
    logic [15:0]       crc;
    logic [LWIDTH-1:0] len;
    logic              reg_free;
    logic              accept;
    logic              keep;

    // One byte of the reflected MODBUS CRC-16, LSB first.
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {8'h00, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        end
        return r;
    endfunction

    // The output register can take a new byte when empty or draining this cycle.
    assign reg_free = !out_valid || out_ready;
    assign in_ready = (state == ST_DATA) && reg_free;
    assign accept   = in_valid && in_ready;
    assign keep     = (len < PAYMAX);

    // Framer state machine, CRC engine, length counter and output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_DATA;
            crc         <= 16'hFFFF;
            len         <= '0;
            out_valid   <= 1'b0;
            out_data    <= 8'h00;
            out_last    <= 1'b0;
            busy        <= 1'b0;
            oversize    <= 1'b0;
            frame_count <= 16'h0000;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                ST_DATA: begin
                    if (accept) begin
                        busy <= 1'b1;
                        if (keep) begin
                            out_data  <= in_data;
                            out_last  <= 1'b0;
                            out_valid <= 1'b1;
                            crc       <= crc_step(crc, in_data);
                            len       <= len + 1'b1;
                        end else begin
                            oversize <= 1'b1;
                        end
                        if (in_last) begin
                            state <= ST_CRCLO;
                        end
                    end
                end
                ST_CRCLO: begin
                    if (reg_free) begin
                        out_data  <= crc[7:0];
                        out_last  <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= ST_CRCHI;
                    end
                end
                ST_CRCHI: begin
                    if (reg_free) begin
                        out_data    <= crc[15:8];
                        out_last    <= 1'b1;
                        out_valid   <= 1'b1;
                        crc         <= 16'hFFFF;
                        len         <= '0;
                        busy        <= 1'b0;
                        frame_count <= frame_count + 16'd1;
                        state       <= ST_DATA;
                    end
                end
                default: begin
                    state <= ST_DATA;
                end
            endcase
        end
    end

endmodule
